// File: rtl/ts_serial_deser_pkg.sv
// ts_serial_deser_pkg
//   Shared definitions for the serial MPEG-TS receiver: packet framing
//   constants, receiver FSM states and the registered output byte record.
package ts_serial_deser_pkg;

  localparam int          PKT_LEN         = 188;
  localparam logic [7:0]  SYNC_BYTE       = 8'h47;
  localparam int          SYNC_STAGES_DEF = 2;
  localparam int          CNT_W_DEF       = 16;
  localparam int          BYTE_IDX_W      = $clog2(PKT_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } ts_byte_t;

endpackage

// File: rtl/ts_serial_deser_pin_sync.sv
// ts_serial_deser_pin_sync
//   Brings the four asynchronous serial TS pins into the clk domain through
//   identical SYNC_STAGES-deep flop chains, so data/start/valid stay aligned
//   with the ts_clk edge they belong to, and detects the ts_clk rising edge.
// Ports
//   clk, reset_n     system clock, async active-low reset
//   i_ts_clk         serial bit clock pin
//   i_ts_data        serial data pin
//   i_ts_valid       bit qualifier pin
//   i_ts_start       packet start marker pin
//   o_bit_evt        1-clk pulse: synced ts_clk 0->1 with synced ts_valid=1
//   o_data           synced data, meaningful with o_bit_evt
//   o_start          synced start, meaningful with o_bit_evt
module ts_serial_deser_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ts_clk,
  input  logic i_ts_data,
  input  logic i_ts_valid,
  input  logic i_ts_start,
  output logic o_bit_evt,
  output logic o_data,
  output logic o_start
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0] r_valid_sync;
  logic [SYNC_STAGES-1:0] r_start_sync;
  logic                   r_clk_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync   <= '0;
      r_data_sync  <= '0;
      r_valid_sync <= '0;
      r_start_sync <= '0;
      r_clk_prev   <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0],   i_ts_clk};
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0],  i_ts_data};
      r_valid_sync <= {r_valid_sync[SYNC_STAGES-2:0], i_ts_valid};
      r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], i_ts_start};
      r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign o_bit_evt = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev & r_valid_sync[SYNC_STAGES-1];
  assign o_data    = r_data_sync[SYNC_STAGES-1];
  assign o_start   = r_start_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ts_serial_deser.sv
// ts_serial_deser
//   Serial MPEG-TS receiver for one demod port. Assembles MSB-first bytes from
//   the synchronized pins, frames PKT_LEN-byte packets and streams them out as
//   single-clk strobes (no backpressure) in the system clock domain.
//   Optional build macro TS_SYNC_CHECK_EN: byte 0 of each packet must equal
//   SYNC_BYTE, otherwise the packet is dropped until the next ts_start.
// Ports
//   clk, reset_n      system clock, async active-low reset
//   ts_clk/ts_data/ts_valid/ts_start   asynchronous serial TS pins
//   enable            1 = receive, 0 = flush to IDLE
//   out_data/out_valid/out_sop/out_eop byte stream
//   out_abort         1-clk pulse: discard current partial packet
//   pkt_cnt           completed packets (wraps)
//   err_cnt           framing/sync errors (saturates)
//   locked            last packet completed without error
//
// state | meaning
// IDLE  | waiting for a ts_start bit event
// RECV  | assembling bytes of a packet
// DROP  | bad sync byte seen, ignoring bits until next ts_start
module ts_serial_deser
  import ts_serial_deser_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ts_clk,
  input  logic             ts_data,
  input  logic             ts_valid,
  input  logic             ts_start,
  input  logic             enable,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_abort,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             locked
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(PKT_LEN - 1);

  logic                  w_bit_evt;
  logic                  w_data;
  logic                  w_start;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [6:0]            r_shift;
  logic [6:0]            w_shift_nxt;
  logic [2:0]            r_bit_idx;
  logic [2:0]            w_bit_nxt;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [BYTE_IDX_W-1:0] w_byte_nxt;
  logic [7:0]            w_byte;
  logic                  w_sync_bad;

  ts_byte_t              r_out;
  ts_byte_t              w_out_nxt;
  logic                  r_out_valid;
  logic                  w_valid_nxt;
  logic                  r_abort;
  logic                  w_abort_nxt;
  logic [CNT_W-1:0]      r_pkt_cnt;
  logic [CNT_W-1:0]      r_err_cnt;
  logic                  w_pkt_inc;
  logic                  w_err_inc;
  logic                  r_locked;
  logic                  w_locked_nxt;

  ts_serial_deser_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_ts_clk   (ts_clk),
    .i_ts_data  (ts_data),
    .i_ts_valid (ts_valid),
    .i_ts_start (ts_start),
    .o_bit_evt  (w_bit_evt),
    .o_data     (w_data),
    .o_start    (w_start)
  );

  // Byte as it would be with the current bit appended; only used on bit 0.
  assign w_byte = {r_shift, w_data};

`ifdef TS_SYNC_CHECK_EN
  assign w_sync_bad = (r_byte_idx == '0) && (w_byte != SYNC_BYTE);
`else
  assign w_sync_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bit_nxt    = r_bit_idx;
    w_byte_nxt   = r_byte_idx;
    w_out_nxt    = '0;
    w_valid_nxt  = 1'b0;
    w_abort_nxt  = 1'b0;
    w_pkt_inc    = 1'b0;
    w_err_inc    = 1'b0;
    w_locked_nxt = r_locked;

    if (!enable) begin
      // Flush; a bit event in this cycle is discarded. Abort only if the
      // consumer has already seen bytes of the packet.
      w_state_nxt  = IDLE;
      w_bit_nxt    = '0;
      w_byte_nxt   = '0;
      w_locked_nxt = 1'b0;
      w_abort_nxt  = (r_state == RECV) && (r_byte_idx != '0);
    end else if (w_bit_evt) begin
      if (w_start) begin
        if ((r_state == RECV) && ((r_byte_idx != '0) || (r_bit_idx != '0))) begin
          w_abort_nxt  = 1'b1;
          w_err_inc    = 1'b1;
          w_locked_nxt = 1'b0;
        end
        // The start bit itself is bit 7 of byte 0.
        w_state_nxt = RECV;
        w_shift_nxt = {6'd0, w_data};
        w_bit_nxt   = 3'd1;
        w_byte_nxt  = '0;
      end else if (r_state == RECV) begin
        w_shift_nxt = {r_shift[5:0], w_data};
        w_bit_nxt   = r_bit_idx + 3'd1;
        if (r_bit_idx == 3'd7) begin
          if (w_sync_bad) begin
            w_err_inc    = 1'b1;
            w_locked_nxt = 1'b0;
            w_state_nxt  = DROP;
            w_byte_nxt   = '0;
          end else begin
            w_valid_nxt    = 1'b1;
            w_out_nxt.data = w_byte;
            w_out_nxt.sop  = (r_byte_idx == '0);
            w_out_nxt.eop  = (r_byte_idx == LAST_BYTE);
            if (r_byte_idx == LAST_BYTE) begin
              w_state_nxt  = IDLE;
              w_byte_nxt   = '0;
              w_pkt_inc    = 1'b1;
              w_locked_nxt = 1'b1;
            end else begin
              w_byte_nxt = r_byte_idx + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_abort     <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_byte_idx  <= w_byte_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_valid_nxt;
      r_abort     <= w_abort_nxt;
      r_locked    <= w_locked_nxt;
      if (w_pkt_inc) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (w_err_inc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign out_data  = r_out.data;
  assign out_sop   = r_out.sop;
  assign out_eop   = r_out.eop;
  assign out_valid = r_out_valid;
  assign out_abort = r_abort;
  assign pkt_cnt   = r_pkt_cnt;
  assign err_cnt   = r_err_cnt;
  assign locked    = r_locked;

endmodule

// File: tb/tb_ts_serial_deser.sv
module tb_ts_serial_deser;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ts_clk = 1'b0;
  logic ts_data = 1'b0;
  logic ts_valid = 1'b0;
  logic ts_start = 1'b0;
  logic enable = 1'b0;

  logic [7:0]  out_data;
  logic        out_valid, out_sop, out_eop, out_abort, locked;
  logic [15:0] pkt_cnt, err_cnt;

  logic [7:0]  n4_data;
  logic        n4_valid, n4_sop, n4_eop, n4_abort, n4_locked;
  logic [3:0]  n4_pkt, n4_err;

  always #5 clk = ~clk;

  ts_serial_deser dut (
    .clk(clk), .reset_n(reset_n), .ts_clk(ts_clk), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_start(ts_start), .enable(enable),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_abort(out_abort), .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt), .locked(locked)
  );

  ts_serial_deser #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .ts_clk(ts_clk), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_start(ts_start), .enable(enable),
    .out_data(n4_data), .out_valid(n4_valid), .out_sop(n4_sop),
    .out_eop(n4_eop), .out_abort(n4_abort), .pkt_cnt(n4_pkt),
    .err_cnt(n4_err), .locked(n4_locked)
  );

`ifdef TS_SYNC_CHECK_EN
  localparam int ERR_AFTER_T3 = 2;
  localparam int PKT_AFTER_T3 = 4;
`else
  localparam int ERR_AFTER_T3 = 1;
  localparam int PKT_AFTER_T3 = 5;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       abort;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  bit         m_in_pkt = 0;
  int         m_bits = 0;
  logic [7:0] m_cur = '0;
  int         m_pkt = 0;
  int         m_err = 0;
  bit         m_locked = 0;

  function automatic void push_ev(input logic a, input logic s, input logic e, input logic [7:0] d);
    ev_t ev;
    ev.abort = a; ev.sop = s; ev.eop = e; ev.data = d;
    exp_q.push_back(ev);
  endfunction

  function automatic void model_bit(input logic d, input logic s);
    int  idx;
    bit  bad;
    if (s) begin
      if (m_in_pkt) begin
        push_ev(1'b1, 1'b0, 1'b0, 8'h00);
        m_err++;
        m_locked = 0;
      end
      m_in_pkt = 1;
      m_bits   = 1;
      m_cur    = {7'd0, d};
    end else if (m_in_pkt) begin
      m_cur  = {m_cur[6:0], d};
      m_bits = m_bits + 1;
      if (m_bits % 8 == 0) begin
        idx = m_bits / 8 - 1;
`ifdef TS_SYNC_CHECK_EN
        bad = (idx == 0) && (m_cur != 8'h47);
`else
        bad = 0;
`endif
        if (bad) begin
          m_err++;
          m_locked = 0;
          m_in_pkt = 0;
        end else begin
          push_ev(1'b0, idx == 0, idx == 187, m_cur);
          if (idx == 187) begin
            m_pkt++;
            m_locked = 1;
            m_in_pkt = 0;
          end
        end
      end
    end
  endfunction

  function automatic void model_disable();
    if (m_in_pkt && m_bits >= 8) push_ev(1'b1, 1'b0, 1'b0, 8'h00);
    m_in_pkt = 0;
    m_locked = 0;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_in_pkt = 0; m_bits = 0; m_cur = '0;
    m_pkt = 0; m_err = 0; m_locked = 0;
  endfunction

  // ---------------- compare process ----------------
  int n_valid = 0, n_sop = 0, n_eop = 0, n_abort = 0;

  always @(negedge clk) begin
    ev_t ev;
    if (reset_n) begin
      if (out_valid || out_abort) check("valid_abort_exclusive", {31'd0, out_valid & out_abort}, 32'd0);
      if (!out_valid && (out_sop || out_eop)) check("sop_eop_without_valid", {30'd0, out_sop, out_eop}, 32'd0);
      if (out_valid) begin n_valid++; n_sop += out_sop; n_eop += out_eop; end
      if (out_abort) n_abort++;
      if (out_valid || out_abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {22'd0, out_abort, out_valid, out_data}, 32'hFFFF_FFFF);
        end else begin
          ev = exp_q.pop_front();
          check("event_is_abort", {31'd0, out_abort}, {31'd0, ev.abort});
          if (!ev.abort && out_valid)
            check("byte_sop_eop_data", {22'd0, out_sop, out_eop, out_data}, {22'd0, ev.sop, ev.eop, ev.data});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int hp = 4;
  bit gap_on = 0;
  int gap_ctr = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input int n);
    ts_valid = 1'b0;
    repeat (n) begin
      ts_data  = 1'($urandom);
      ts_start = 1'($urandom);
      wait_clk(hp);
      ts_clk = 1'b1;
      wait_clk(hp);
      ts_clk = 1'b0;
    end
    ts_start = 1'b0;
  endtask

  task automatic send_bit(input logic d, input logic s);
    ts_data  = d;
    ts_start = s;
    ts_valid = 1'b1;
    wait_clk(hp);
    ts_clk = 1'b1;
    model_bit(d, s);
    wait_clk(hp);
    ts_clk = 1'b0;
    if (gap_on) begin
      gap_ctr++;
      if (gap_ctr % 3 == 0) gap(5);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic first);
    for (int i = 7; i >= 0; i--) send_bit(b[i], first && (i == 7));
  endtask

  task automatic send_pkt(input logic [7:0] b0, input int n, input bit pattern);
    send_byte(b0, 1'b1);
    for (int k = 1; k < n; k++) send_byte(pattern ? 8'(k - 1) : 8'($urandom), 1'b0);
  endtask

  task automatic checkpoint(input string tag);
    wait_clk(16);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    check({tag, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'(m_pkt & 16'hFFFF));
    check({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'(m_err));
    check({tag, "_locked"}, {31'd0, locked}, {31'd0, m_locked});
    check({tag, "_pkt_cnt_w4"}, {28'd0, n4_pkt}, 32'(m_pkt % 16));
    check({tag, "_err_cnt_w4_sat"}, {28'd0, n4_err}, 32'((m_err > 15) ? 15 : m_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    check("reset_outputs", {pkt_cnt, err_cnt}, 32'd0);
    check("reset_flags", {27'd0, out_valid, out_sop, out_eop, out_abort, locked}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_clk(4);

    // T1: three packets 0x47,0x00..0xBA at ts_clk = clk/8
    hp = 4;
    for (int p = 0; p < 3; p++) send_pkt(8'h47, 188, 1'b1);
    checkpoint("t1");
    check("t1_pkt_literal", {16'd0, pkt_cnt}, 32'd3);
    check("t1_model_pkt_literal", m_pkt, 3);
    check("t1_valid_count", n_valid, 564);
    check("t1_sop_count", n_sop, 3);
    check("t1_eop_count", n_eop, 3);
    check("t1_locked_literal", {31'd0, locked}, 32'd1);

    // T2/T3: restart at byte 100 into a packet with bad sync, then a good one
    hp = 2;
    send_pkt(8'h47, 100, 1'b0);
    send_byte(8'h48, 1'b1);
    wait_clk(12);
    check("t2_abort_count", n_abort, 1);
    check("t2_locked_after_abort", {31'd0, locked}, 32'd0);
    for (int k = 1; k < 188; k++) send_byte(8'($urandom), 1'b0);
    checkpoint("t3_bad");
    send_pkt(8'h47, 188, 1'b0);
    checkpoint("t3_good");
    check("t3_err_literal", {16'd0, err_cnt}, 32'(ERR_AFTER_T3));
    check("t3_pkt_literal", {16'd0, pkt_cnt}, 32'(PKT_AFTER_T3));
    check("t3_locked_literal", {31'd0, locked}, 32'd1);

    // T5: enable dropped at byte 50
    send_pkt(8'h47, 50, 1'b0);
    wait_clk(10);
    enable = 1'b0;
    model_disable();
    wait_clk(4);
    check("t5_abort_count", n_abort, 2);
    check("t5_err_unchanged", {16'd0, err_cnt}, 32'(ERR_AFTER_T3));
    check("t5_locked_cleared", {31'd0, locked}, 32'd0);
    enable = 1'b1;
    wait_clk(4);
    // non-start bits after re-enable must be ignored (state IDLE)
    send_byte(8'hA5, 1'b0);
    checkpoint("t5_idle");

    // reset mid-packet
    send_pkt(8'h47, 30, 1'b0);
    wait_clk(10);
    reset_n = 1'b0;
    #1;
    check("t5_reset_counts", {pkt_cnt, err_cnt}, 32'd0);
    check("t5_reset_flags", {19'd0, out_data, out_valid, out_sop, out_eop, out_abort, locked}, 32'd0);
    model_reset();
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);

    // T4: gapped packet right after reset release
    gap_on = 1;
    send_pkt(8'h47, 188, 1'b0);
    gap_on = 0;
    checkpoint("t4");
    check("t4_pkt_literal", {16'd0, pkt_cnt}, 32'd1);
    check("t4_err_literal", {16'd0, err_cnt}, 32'd0);
    check("t4_locked_literal", {31'd0, locked}, 32'd1);

    // T6: 20 aborts, narrow counter saturates
    for (int a = 0; a < 21; a++) send_byte(8'h47, 1'b1);
    checkpoint("t6");
    check("t6_err16_literal", {16'd0, err_cnt}, 32'd20);
    check("t6_err4_literal", {28'd0, n4_err}, 32'd15);
    check("t6_locked_literal", {31'd0, locked}, 32'd0);

    // random tail: partial packets of random length, random gaps, then flush
    for (int r = 0; r < 4; r++) begin
      gap_on = 1'($urandom);
      send_pkt(8'h47, $urandom_range(1, 8), 1'b0);
      for (int b = 0; b < $urandom_range(0, 7); b++) send_bit(1'($urandom), 1'b0);
    end
    gap_on = 0;
    wait_clk(10);
    enable = 1'b0;
    model_disable();
    wait_clk(4);
    enable = 1'b1;
    checkpoint("tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
